// File: rtl/note_lane_engine.sv
// Rhythm-game core: falling notes in 4 lanes, frame-synchronous advance,
// key-strum judging with score/combo, and a registered per-pixel note flag.
module note_lane_engine #(
    parameter int SLOTS   = 8,
    parameter int SPEED   = 2,
    parameter int HIT_Y   = 400,
    parameter int WINDOW  = 12,
    parameter int LANE_X0 = 200,
    parameter int LANE_W  = 60,
    parameter int NOTE_W  = 48,
    parameter int NOTE_H  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VGA_VS,
    input  logic        spawn_valid,
    input  logic [1:0]  spawn_lane,
    output logic        spawn_ready,
    input  logic [7:0]  keycode,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        note_on,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    localparam int          IDX_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [10:0] SPEED_C   = 11'(SPEED);
    localparam logic [10:0] WIN_LO_C  = 11'(HIT_Y - WINDOW);
    localparam logic [10:0] WIN_HI_C  = 11'(HIT_Y + WINDOW);
    localparam logic [10:0] LANE_X0_C = 11'(LANE_X0);
    localparam logic [10:0] LANE_W_C  = 11'(LANE_W);
    localparam logic [10:0] NOTE_W_C  = 11'(NOTE_W);
    localparam logic [10:0] NOTE_H_C  = 11'(NOTE_H);

    logic [SLOTS-1:0] valid_r;
    logic [1:0]       lane_r [SLOTS];
    logic [9:0]       y_r    [SLOTS];
    logic             vs_prev_r;
    logic [7:0]       key_prev_r;
    logic [15:0]      score_r;
    logic [7:0]       combo_r;
    logic             hit_pulse_r;
    logic             miss_pulse_r;
    logic             note_on_r;

    logic [SLOTS-1:0] valid_n_s;
    logic [1:0]       lane_n_s [SLOTS];
    logic [9:0]       y_n_s    [SLOTS];
    logic [10:0]      y_inc_s  [SLOTS];
    logic [SLOTS-1:0] pix_s;
    logic             frame_tick_s;
    logic             key_is_lane_s;
    logic [1:0]       key_lane_s;
    logic             strum_s;
    logic             cand_found_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic [9:0]       cand_y_s;
    logic             hit_s;
    logic             adv_miss_s;
    logic             miss_s;
    logic             spawn_ready_s;
    logic             spawn_acc_s;
    logic             spawn_free_found_s;
    logic [IDX_W-1:0] spawn_idx_s;

    // Returns {is_lane_key, lane} for a HID keycode.
    function automatic logic [2:0] decode_key(input logic [7:0] kc);
        logic [2:0] res;
        case (kc)
            8'h04:   res = 3'b100;
            8'h16:   res = 3'b101;
            8'h07:   res = 3'b110;
            8'h09:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    assign {key_is_lane_s, key_lane_s} = decode_key(keycode);
    assign frame_tick_s  = vs_prev_r && !VGA_VS;
    assign strum_s       = (keycode != key_prev_r) && key_is_lane_s;
    assign hit_s         = strum_s && cand_found_s;
    assign miss_s        = (strum_s && !cand_found_s) || adv_miss_s;
    assign spawn_ready_s = |(~valid_r);
    assign spawn_acc_s   = spawn_valid && spawn_ready_s;

    // Per-slot advance sum and pixel coverage; 11-bit so y+NOTE_H cannot wrap.
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        logic [10:0] x0_s;
        logic [10:0] y_ext_s;
        assign y_ext_s    = {1'b0, y_r[g]};
        assign y_inc_s[g] = y_ext_s + SPEED_C;
        assign x0_s       = LANE_X0_C + ({9'd0, lane_r[g]} * LANE_W_C);
        assign pix_s[g]   = valid_r[g]
                          && ({1'b0, DrawX} >= x0_s) && ({1'b0, DrawX} < (x0_s + NOTE_W_C))
                          && ({1'b0, DrawY} >= y_ext_s) && ({1'b0, DrawY} < (y_ext_s + NOTE_H_C));
    end

    // Strike candidate: deepest in-window note of the struck lane, lowest index on a tie.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = '0;
        cand_y_s     = 10'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_r[i] && (lane_r[i] == key_lane_s)
                && ({1'b0, y_r[i]} >= WIN_LO_C) && ({1'b0, y_r[i]} <= WIN_HI_C)
                && (!cand_found_s || (y_r[i] > cand_y_s))) begin
                cand_found_s = 1'b1;
                cand_idx_s   = IDX_W'(i);
                cand_y_s     = y_r[i];
            end else begin
                cand_found_s = cand_found_s;
            end
        end
    end

    // Lowest-index slot that is free before this cycle's hits and misses.
    always_comb begin
        spawn_free_found_s = 1'b0;
        spawn_idx_s        = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!valid_r[i] && !spawn_free_found_s) begin
                spawn_free_found_s = 1'b1;
                spawn_idx_s        = IDX_W'(i);
            end else begin
                spawn_free_found_s = spawn_free_found_s;
            end
        end
    end

    // Slot next state: a spawn only lands in a pre-free slot, a hit slot skips the advance.
    always_comb begin
        valid_n_s  = valid_r;
        adv_miss_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            lane_n_s[i] = lane_r[i];
            y_n_s[i]    = y_r[i];
            if (spawn_acc_s && (spawn_idx_s == IDX_W'(i))) begin
                valid_n_s[i] = 1'b1;
                lane_n_s[i]  = spawn_lane;
                y_n_s[i]     = 10'd0;
            end else if (hit_s && (cand_idx_s == IDX_W'(i))) begin
                valid_n_s[i] = 1'b0;
            end else if (frame_tick_s && valid_r[i]) begin
                if (y_inc_s[i] > WIN_HI_C) begin
                    valid_n_s[i] = 1'b0;
                    adv_miss_s   = 1'b1;
                end else begin
                    y_n_s[i] = y_inc_s[i][9:0];
                end
            end else begin
                valid_n_s[i] = valid_r[i];
            end
        end
    end

    // Slot storage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_r <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                lane_r[i] <= 2'd0;
                y_r[i]    <= 10'd0;
            end
        end else begin
            valid_r <= valid_n_s;
            for (int i = 0; i < SLOTS; i++) begin
                lane_r[i] <= lane_n_s[i];
                y_r[i]    <= y_n_s[i];
            end
        end
    end

    // Edge detectors, score/combo, pulses and the pixel flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_prev_r    <= 1'b1;
            key_prev_r   <= 8'd0;
            score_r      <= 16'd0;
            combo_r      <= 8'd0;
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
            note_on_r    <= 1'b0;
        end else begin
            vs_prev_r    <= VGA_VS;
            key_prev_r   <= keycode;
            hit_pulse_r  <= hit_s;
            miss_pulse_r <= miss_s;
            note_on_r    <= |pix_s;
            if (hit_s && (score_r != 16'hFFFF)) begin
                score_r <= score_r + 16'd1;
            end else begin
                score_r <= score_r;
            end
            if (miss_s) begin
                combo_r <= 8'd0;
            end else if (hit_s && (combo_r != 8'hFF)) begin
                combo_r <= combo_r + 8'd1;
            end else begin
                combo_r <= combo_r;
            end
        end
    end

    assign spawn_ready = spawn_ready_s;
    assign note_on     = note_on_r;
    assign score       = score_r;
    assign combo       = combo_r;
    assign hit_pulse   = hit_pulse_r;
    assign miss_pulse  = miss_pulse_r;

endmodule
